// File: rtl/wave_osc_bank.sv
// Bank of time-multiplexed square/pulse oscillator voices feeding a saturating mixer.
// One voice is stepped per clock after each sample_tick, and one mixed sample is produced per tick.
module wave_osc_bank #(
    parameter int VOICES     = 4,
    parameter int DATA_W     = 24,
    parameter int LEN_W      = 16,
    parameter int GAIN_SHIFT = 4,
    localparam int VW        = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_tick,
    input  logic                     cfg_we,
    input  logic [VW-1:0]            cfg_voice,
    input  logic [1:0]               cfg_addr,
    input  logic [15:0]              cfg_data,
    output logic signed [DATA_W-1:0] mix_out,
    output logic                     mix_valid,
    output logic                     busy,
    output logic                     overrun
);
    // state  | meaning
    // S_IDLE | waiting for sample_tick
    // S_RUN  | stepping voice idx and accumulating its level
    // S_DONE | saturating the sum onto mix_out, pulsing mix_valid
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam int SW = 17 + $clog2(VOICES);
    localparam int XW = (SW + GAIN_SHIFT > DATA_W) ? SW + GAIN_SHIFT : DATA_W;
    localparam logic signed [XW-1:0] SAT_MAX = {{(XW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_MIN = {{(XW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t                state;
    logic [VW-1:0]         idx;
    logic signed [SW-1:0]  acc;

    logic [LEN_W-1:0]      wave_len [VOICES];
    logic [LEN_W-1:0]      duty     [VOICES];
    logic [15:0]           amp      [VOICES];
    logic [1:0]            mode     [VOICES];
    logic [LEN_W-1:0]      cnt      [VOICES];
    logic                  phase    [VOICES];

    logic [LEN_W-1:0]      cur_wl, cur_duty, cur_cnt, next_cnt;
    logic [15:0]           cur_amp;
    logic [1:0]            cur_mode;
    logic                  cur_ph, cur_active, toggle, next_ph, pulse_as_sq;
    logic signed [16:0]    amp_s, level;
    logic signed [XW-1:0]  scaled;
    logic signed [DATA_W-1:0] mix_sat;
    logic                  step_en;

    assign step_en = (state == S_RUN);

    always_comb begin
        cur_wl      = wave_len[idx];
        cur_duty    = duty[idx];
        cur_cnt     = cnt[idx];
        cur_amp     = amp[idx];
        cur_mode    = mode[idx];
        cur_ph      = phase[idx];
        cur_active  = (cur_mode == 2'd1) || (cur_mode == 2'd2);
        pulse_as_sq = (cur_duty == '0) || (cur_duty >= cur_wl);
        toggle      = 1'b0;
        if (cur_wl <= LEN_W'(1))
            toggle = 1'b1;
        else if (cur_mode == 2'd2 && !pulse_as_sq)
            toggle = cur_ph ? (cur_cnt >= cur_duty) : (cur_cnt >= cur_wl - cur_duty);
        else
            toggle = ({cur_cnt, 1'b0} >= {1'b0, cur_wl});
        next_ph  = toggle ? ~cur_ph : cur_ph;
        next_cnt = toggle ? LEN_W'(1) : cur_cnt + LEN_W'(1);
        amp_s    = {1'b0, cur_amp};
        if (!cur_active)
            level = '0;
        else
            level = next_ph ? amp_s : -amp_s;
    end

    always_comb begin
        scaled = XW'(acc) <<< GAIN_SHIFT;
        if (scaled > SAT_MAX)
            mix_sat = {1'b0, {(DATA_W-1){1'b1}}};
        else if (scaled < SAT_MIN)
            mix_sat = {1'b1, {(DATA_W-1){1'b0}}};
        else
            mix_sat = scaled[DATA_W-1:0];
    end

    // A phase_reset write is applied after the step, so it overrides that voice's update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < VOICES; v++) begin
                wave_len[v] <= '0;
                duty[v]     <= '0;
                amp[v]      <= '0;
                mode[v]     <= 2'd0;
                cnt[v]      <= LEN_W'(1);
                phase[v]    <= 1'b0;
            end
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                if (step_en && idx == VW'(v) && cur_active) begin
                    cnt[v]   <= next_cnt;
                    phase[v] <= next_ph;
                end
                if (cfg_we && cfg_voice == VW'(v)) begin
                    case (cfg_addr)
                        2'd0: wave_len[v] <= LEN_W'(cfg_data);
                        2'd1: duty[v]     <= LEN_W'(cfg_data);
                        2'd2: amp[v]      <= cfg_data;
                        default: begin
                            mode[v] <= cfg_data[1:0];
                            if (cfg_data[2]) begin
                                cnt[v]   <= LEN_W'(1);
                                phase[v] <= 1'b0;
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            acc       <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            overrun   <= sample_tick && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (sample_tick) begin
                        acc   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc <= acc + SW'(level);
                    if (idx == VW'(VOICES - 1))
                        state <= S_DONE;
                    else
                        idx <= idx + VW'(1);
                end
                S_DONE: begin
                    mix_out   <= mix_sat;
                    mix_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wave_osc_bank.sv
// Directed bench for wave_osc_bank (4 voices, 20-bit mix so saturation is reachable).
module tb_wave_osc_bank;
    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               sample_tick = 1'b0;
    logic               cfg_we = 1'b0;
    logic [1:0]         cfg_voice = '0;
    logic [1:0]         cfg_addr = '0;
    logic [15:0]        cfg_data = '0;
    logic signed [19:0] mix_out;
    logic               mix_valid, busy, overrun;

    int n_cmp = 0;
    int n_bad = 0;

    wave_osc_bank #(.VOICES(4), .DATA_W(20), .LEN_W(16), .GAIN_SHIFT(4)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick),
        .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] v, input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_voice = v; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic cfg_voice_all(input logic [1:0] v, input logic [15:0] wl, input logic [15:0] du,
                                 input logic [15:0] am, input logic [15:0] ctrl);
        cfg_write(v, 2'd0, wl);
        cfg_write(v, 2'd1, du);
        cfg_write(v, 2'd2, am);
        cfg_write(v, 2'd3, ctrl);
    endtask

    // j counts negedges after the edge that sampled the tick; -1 latency means no mix_valid seen.
    task automatic run_tick(output logic signed [19:0] val, output int lat);
        lat = -1; val = '0;
        @(negedge clk) sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
        for (int j = 0; j <= 12; j++) begin
            if (mix_valid === 1'b1) begin
                lat = j; val = mix_out;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (mix_out !== 20'sd0) begin n_bad++; $display("FAIL reset mix_out: got %0d want 0", mix_out); end
        n_cmp++; if (mix_valid !== 1'b0) begin n_bad++; $display("FAIL reset mix_valid: got %b want 0", mix_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset overrun: got %b want 0", overrun); end
        reset = 1'b0;
        @(negedge clk) sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
        for (int j = 0; j <= 7; j++) begin
            n_cmp++;
            if (busy !== (j <= 4)) begin n_bad++; $display("FAIL idle_tick busy j=%0d: got %b want %b", j, busy, (j <= 4)); end
            n_cmp++;
            if (mix_valid !== (j == 5)) begin n_bad++; $display("FAIL idle_tick mix_valid j=%0d: got %b want %b", j, mix_valid, (j == 5)); end
            if (j == 5) begin
                n_cmp++;
                if (mix_out !== 20'sd0) begin n_bad++; $display("FAIL idle_tick mix_out: got %0d want 0", mix_out); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_square();
        int sgn[11] = '{-1, -1, -1, 1, 1, 1, 1, -1, -1, -1, -1};
        logic signed [19:0] v;
        int lat;
        do_reset();
        cfg_voice_all(2'd0, 16'd8, 16'd0, 16'd1000, 16'd1);
        for (int i = 0; i < 11; i++) begin
            run_tick(v, lat);
            n_cmp++;
            if (v !== sgn[i] * 16000 || lat != 5) begin
                n_bad++; $display("FAIL square tick %0d: got %0d (lat %0d) want %0d (lat 5)", i, v, lat, sgn[i] * 16000);
            end
        end
    endtask

    task automatic test_pulse();
        int sgn[19] = '{-1, -1, -1, -1, -1, -1, 1, 1, 1, -1, -1, -1, -1, -1, -1, -1, 1, 1, 1};
        int sq[14]  = '{-1, -1, -1, -1, 1, 1, 1, 1, 1, -1, -1, -1, -1, -1};
        logic signed [19:0] v;
        int lat;
        do_reset();
        cfg_voice_all(2'd1, 16'd10, 16'd3, 16'd500, 16'd2);
        for (int i = 0; i < 19; i++) begin
            run_tick(v, lat);
            n_cmp++;
            if (v !== sgn[i] * 8000) begin n_bad++; $display("FAIL pulse tick %0d: got %0d want %0d", i, v, sgn[i] * 8000); end
        end
        do_reset();
        cfg_voice_all(2'd1, 16'd10, 16'd0, 16'd500, 16'd2);
        for (int i = 0; i < 14; i++) begin
            run_tick(v, lat);
            n_cmp++;
            if (v !== sq[i] * 8000) begin n_bad++; $display("FAIL pulse_duty0 tick %0d: got %0d want %0d", i, v, sq[i] * 8000); end
        end
    endtask

    task automatic test_saturation();
        int exp_a[4] = '{-524288, 524287, 524287, -524288};
        int exp_b[3] = '{0, 524287, 0};
        logic signed [19:0] v;
        int lat;
        do_reset();
        for (int k = 0; k < 4; k++) cfg_voice_all(2'(k), 16'd4, 16'd0, 16'hFFFF, 16'd1);
        for (int i = 0; i < 4; i++) begin
            run_tick(v, lat);
            n_cmp++;
            if (v !== exp_a[i]) begin n_bad++; $display("FAIL sat_inphase tick %0d: got %0d want %0d", i, v, exp_a[i]); end
        end
        do_reset();
        cfg_voice_all(2'd0, 16'd4, 16'd0, 16'hFFFF, 16'd1);
        cfg_voice_all(2'd1, 16'd4, 16'd0, 16'hFFFF, 16'd1);
        run_tick(v, lat);
        n_cmp++;
        if (v !== -20'sd524288) begin n_bad++; $display("FAIL sat_two_low: got %0d want -524288", v); end
        cfg_voice_all(2'd2, 16'd4, 16'd0, 16'hFFFF, 16'd1);
        cfg_voice_all(2'd3, 16'd4, 16'd0, 16'hFFFF, 16'd1);
        for (int i = 0; i < 3; i++) begin
            run_tick(v, lat);
            n_cmp++;
            if (v !== exp_b[i]) begin n_bad++; $display("FAIL sat_mixed tick %0d: got %0d want %0d", i, v, exp_b[i]); end
        end
    endtask

    // Collisions: second tick sampled 2 edges later (RUN), then a tick sampled in DONE.
    task automatic test_overrun();
        int coll[2] = '{1, 4};
        int n_ovr, ovr_j, n_val;
        do_reset();
        for (int s = 0; s < 2; s++) begin
            n_ovr = 0; ovr_j = -1; n_val = 0;
            @(negedge clk) sample_tick = 1'b1;
            @(negedge clk) sample_tick = 1'b0;
            for (int j = 0; j <= 14; j++) begin
                if (overrun === 1'b1) begin n_ovr++; ovr_j = j; end
                if (mix_valid === 1'b1) n_val++;
                sample_tick = (j == coll[s]);
                @(negedge clk);
            end
            sample_tick = 1'b0;
            n_cmp++;
            if (n_ovr != 1 || ovr_j != coll[s] + 1) begin
                n_bad++; $display("FAIL overrun case %0d: %0d pulses at j=%0d, want 1 at j=%0d", s, n_ovr, ovr_j, coll[s] + 1);
            end
            n_cmp++;
            if (n_val != 1) begin n_bad++; $display("FAIL overrun case %0d mix_valid count: got %0d want 1", s, n_val); end
        end
    endtask

    task automatic test_phase_reset();
        int pre[5]  = '{-1, -1, -1, 1, 1};
        int post[4] = '{-1, -1, -1, 1};
        logic signed [19:0] v;
        int lat;
        do_reset();
        cfg_voice_all(2'd0, 16'd8, 16'd0, 16'd1000, 16'd1);
        for (int i = 0; i < 5; i++) begin
            run_tick(v, lat);
            n_cmp++;
            if (v !== pre[i] * 16000) begin n_bad++; $display("FAIL phrst_pre tick %0d: got %0d want %0d", i, v, pre[i] * 16000); end
        end
        cfg_write(2'd0, 2'd3, 16'h0005);
        for (int i = 0; i < 4; i++) begin
            run_tick(v, lat);
            n_cmp++;
            if (v !== post[i] * 16000) begin n_bad++; $display("FAIL phrst_post tick %0d: got %0d want %0d", i, v, post[i] * 16000); end
        end
    endtask

    // Ticks at the minimum spacing of 6; wave_length 2 alternates sign every sample.
    task automatic test_back_to_back();
        int n_ovr = 0;
        int n_val = 0;
        do_reset();
        cfg_voice_all(2'd0, 16'd2, 16'd0, 16'd1000, 16'd1);
        @(negedge clk) sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
        for (int j = 0; j <= 19; j++) begin
            if (overrun === 1'b1) n_ovr++;
            if (mix_valid === 1'b1) n_val++;
            if (j == 5 || j == 17) begin
                n_cmp++;
                if (mix_valid !== 1'b1 || mix_out !== 20'sd16000) begin
                    n_bad++; $display("FAIL b2b j=%0d: valid %b mix_out %0d, want 1 and 16000", j, mix_valid, mix_out);
                end
            end
            if (j == 11) begin
                n_cmp++;
                if (mix_valid !== 1'b1 || mix_out !== -20'sd16000) begin
                    n_bad++; $display("FAIL b2b j=11: valid %b mix_out %0d, want 1 and -16000", mix_valid, mix_out);
                end
            end
            if (j == 8) begin
                n_cmp++;
                if (mix_out !== 20'sd16000) begin n_bad++; $display("FAIL b2b hold: got %0d want 16000", mix_out); end
            end
            sample_tick = (j == 5 || j == 11);
            @(negedge clk);
        end
        sample_tick = 1'b0;
        n_cmp++;
        if (n_ovr != 0) begin n_bad++; $display("FAIL b2b overrun count: got %0d want 0", n_ovr); end
        n_cmp++;
        if (n_val != 3) begin n_bad++; $display("FAIL b2b mix_valid count: got %0d want 3", n_val); end
    endtask

    task automatic test_reset_mid_run();
        logic signed [19:0] v;
        int lat;
        int n_val = 0;
        do_reset();
        cfg_voice_all(2'd0, 16'd8, 16'd0, 16'd1000, 16'd1);
        run_tick(v, lat);
        n_cmp++;
        if (v !== -20'sd16000) begin n_bad++; $display("FAIL midrst first: got %0d want -16000", v); end
        @(negedge clk) sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (mix_out !== 20'sd0 || busy !== 1'b0 || mix_valid !== 1'b0) begin
            n_bad++; $display("FAIL midrst outputs: mix_out %0d busy %b valid %b, want 0 0 0", mix_out, busy, mix_valid);
        end
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        for (int j = 0; j < 10; j++) begin
            if (mix_valid === 1'b1) n_val++;
            @(negedge clk);
        end
        n_cmp++;
        if (n_val != 0) begin n_bad++; $display("FAIL midrst stray mix_valid: got %0d want 0", n_val); end
        run_tick(v, lat);
        n_cmp++;
        if (v !== 20'sd0 || lat != 5) begin n_bad++; $display("FAIL midrst after: got %0d lat %0d want 0 lat 5", v, lat); end
    endtask

    initial begin
        test_reset();
        test_square();
        test_pulse();
        test_saturation();
        test_overrun();
        test_phase_reset();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wave_osc_bank.md
# wave_osc_bank

Parametrised bank of time-multiplexed square/pulse oscillator voices with a saturating mixer. It is the multi-voice successor to the single square generator and sits between the audio sample-rate tick generator and the audio output path. On each sample tick, every voice advances one step in turn, its signed level is accumulated, and one mixed sample is presented with a valid strobe.

## Interface
- `VOICES`, 4, number of voices (≥1); `VW = max(1, clog2(VOICES))`
- `DATA_W`, 24, width of signed mix output
- `LEN_W`, 16, width of wave_length, duty and counters
- `GAIN_SHIFT`, 4, left shift applied to the voice sum before saturation
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: asynchronous, active-high
- `sample_tick` in 1: one-cycle request to advance all voices one sample
- `cfg_we` in 1: config write strobe
- `cfg_voice` in VW: target voice
- `cfg_addr` in 2: register select
  - 0: wave_length
  - 1: duty
  - 2: amplitude (unsigned)
  - 3: control, where [1:0] = mode (0 off, 1 square, 2 pulse, 3 treated as off) and [2] = phase_reset (self-clearing)
- `cfg_data` in 16: write data; LEN_W bits are used for addr 0/1
- `mix_out` out DATA_W: signed mixed sample
- `mix_valid` out 1: one-cycle strobe, mix_out updated
- `busy` out 1: high while voices are being processed
- `overrun` out 1: one-cycle pulse when sample_tick arrives while busy

## Operation
- Per-voice state: counter (LEN_W, initialised to 1) and phase bit (0 = low, initialised to low). Level = phase ? +amplitude : −amplitude, as a 17-bit signed value.
- **Voice step (mode ≠ off):** compute a toggle condition, then update.
  - Toggle condition, square: counter·2 ≥ wave_length. Compare at LEN_W+1 bits; no overflow.
  - Toggle condition, pulse, phase high: counter ≥ duty.
  - Toggle condition, pulse, phase low: counter ≥ wave_length − duty.
  - Pulse with duty = 0 or duty ≥ wave_length behaves exactly as square.
  - On toggle: phase inverts, counter ← 1, and the contributed level uses the new phase.
  - No toggle: counter ← counter + 1, and the contributed level uses the current phase.
  - wave_length 0 or 1 toggles on every step.
- **Mode off:** the voice contributes 0; counter and phase are frozen.
- **Mix:**
  - sum = Σ levels, at 17+clog2(VOICES) bits signed.
  - scaled = sum <<< GAIN_SHIFT.
  - mix_out = scaled saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- **FSM:**
  - IDLE: on sample_tick, clear the accumulator, set idx = 0, go to RUN.
  - RUN: step voice idx and accumulate. If idx = VOICES−1, go to DONE; otherwise idx+1.
  - DONE: register the saturated mix_out, pulse mix_valid, go to IDLE.
- **Config writes:**
  - Take effect on the next clock edge.
  - If the voice being stepped in the same cycle is written, the step uses the old value.
  - phase_reset = 1 forces counter ← 1 and phase ← low. It has priority over a simultaneous step of that voice; that step's state update is discarded, and it still contributes its old-state level.
- sample_tick in RUN or DONE is ignored (no queueing) and raises overrun.
- **Async reset:**
  - Clears all voice registers: wave_length, duty and amplitude to 0; mode to off; counter to 1; phase to low.
  - Returns the FSM to IDLE.
  - Zeroes all outputs, including mid-RUN; the partial mix is discarded.

## Timing
- Reset values: mix_out = 0, mix_valid = 0, busy = 0, overrun = 0.
- sample_tick sampled at edge T:
  - busy is high for cycles T+1 … T+VOICES+1.
  - Voice k is stepped at edge T+1+k.
  - mix_out and mix_valid are valid for exactly the one cycle after edge T+VOICES+1.
- Latency is VOICES+1 cycles. The minimum tick spacing without overrun is VOICES+2 cycles.
- overrun asserts for one cycle after the edge that sampled the colliding tick.
- mix_out holds its value between mix_valid strobes.

## Test plan
- **Reset, then tick:** reset, then tick with all voices off → mix_valid at T+5 (VOICES=4), mix_out = 0, busy high for 5 cycles.
- **Square:** voice0 square, wave_length 8, amp 1000 → per-tick mix_out −16000 ×3, +16000 ×4, −16000 ×4, repeating.
- **Pulse:** voice1 pulse, wave_length 10, duty 3, amp 500 → −8000 ×6, +8000 ×3, −8000 ×7, +8000 ×3 …; duty 0 gives the square pattern.
- **Saturation:** DATA_W = 20, all 4 voices square, amp 65535, in phase → mix_out = −524288 while low and +524287 once high; mixed phases with net 0 → 0.
- **Overrun and phase_reset:**
  - sample_tick repeated 2 cycles after a tick → overrun pulses once, only one mix_valid.
  - phase_reset on voice0 mid-period → next step restarts with counter 1, low phase.
- **Reset mid-run:** assert reset during RUN → outputs zero immediately, no mix_valid; after release, a tick with voices unconfigured yields mix_out = 0.
